// File: rtl/voice_allocator.sv
// voice_allocator: maps channel-0 note messages onto a pool of voices, stealing one when all are held
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [23:0]           MIDI_MSG,
  input  logic                  MIDI_MSG_RDY,
  input  logic [NUM_VOICES-1:0] VOICE_ACTIVE,
  output logic [23:0]           VOICE_MSG,
  output logic [NUM_VOICES-1:0] VOICE_MSG_RDY,
  output logic                  STEAL,
  output logic [7:0]            OVF_CNT
);
  localparam logic [NUM_VOICES-1:0] ONE = NUM_VOICES'(1);
  typedef enum logic [1:0] {IDLE, DECODE, DISPATCH} state_t;
  state_t state, state_nxt;
  logic [23:0] cur_msg, pend_msg;
  logic pend_vld, take, pend_load, drop;
  logic [NUM_VOICES-1:0] held, free_idle, free_rel, off_mask, on_mask, mask;
  logic [NUM_VOICES-1:0][6:0] note;
  logic [IDX_W-1:0] steal_ptr;
  logic is_on, is_off, is_ano, steal;
  // The pending message always wins in IDLE; a fresh strobe then refills the buffer.
  assign take      = state == IDLE && (MIDI_MSG_RDY || pend_vld);
  assign pend_load = MIDI_MSG_RDY && (state == IDLE ? pend_vld : !pend_vld);
  assign drop      = MIDI_MSG_RDY && state != IDLE && pend_vld;
  // State register
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nxt;
  // Next-state logic: every message walks IDLE -> DECODE -> DISPATCH -> IDLE
  always_comb
    state_nxt = state == IDLE ? (take ? DECODE : IDLE) : state == DECODE ? DISPATCH : IDLE;
  // Decode of the current message into a target mask; VOICE_ACTIVE only matters while in DECODE
  always_comb begin
    is_on     = cur_msg[23:16] == 8'h90 && cur_msg[7:0] != 8'h00;
    is_off    = cur_msg[23:16] == 8'h80 || (cur_msg[23:16] == 8'h90 && cur_msg[7:0] == 8'h00);
    is_ano    = cur_msg[23:16] == 8'hB0 && cur_msg[15:8] == 8'h7B;
    free_idle = ~held & ~VOICE_ACTIVE;
    free_rel  = ~held;
    off_mask  = '0;
    for (int i = 0; i < NUM_VOICES; i++) off_mask[i] = held[i] && note[i] == cur_msg[14:8];
    on_mask   = |free_idle ? free_idle & (~free_idle + ONE) :
                |free_rel  ? free_rel & (~free_rel + ONE) : ONE << steal_ptr;
    steal     = is_on && !(|free_rel);
    mask      = is_on ? on_mask : is_off ? off_mask : is_ano ? '1 : '0;
  end
  // Message intake: current message, 1-deep pending buffer and saturating drop counter
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cur_msg  <= '0;
      pend_msg <= '0;
      pend_vld <= 1'b0;
      OVF_CNT  <= '0;
    end else begin
      if (take) cur_msg <= pend_vld ? pend_msg : MIDI_MSG;
      if (pend_load) pend_msg <= MIDI_MSG;
      pend_vld <= state == IDLE ? pend_vld && MIDI_MSG_RDY : pend_vld || MIDI_MSG_RDY;
      if (drop && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'd1;
    end
  // Registered dispatch strobe out of DECODE; the map and steal pointer commit during DISPATCH
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      VOICE_MSG     <= '0;
      VOICE_MSG_RDY <= '0;
      STEAL         <= 1'b0;
      held          <= '0;
      note          <= '0;
      steal_ptr     <= '0;
    end else begin
      VOICE_MSG_RDY <= state == DECODE ? mask : '0;
      STEAL         <= state == DECODE && steal;
      if (state == DECODE) VOICE_MSG <= cur_msg;
      if (state == DISPATCH) begin
        held <= is_on ? held | VOICE_MSG_RDY : is_off ? held & ~VOICE_MSG_RDY : is_ano ? '0 : held;
        for (int i = 0; i < NUM_VOICES; i++)
          if (is_on && VOICE_MSG_RDY[i]) note[i] <= cur_msg[14:8];
        if (STEAL) steal_ptr <= steal_ptr == IDX_W'(NUM_VOICES - 1) ? '0 : steal_ptr + IDX_W'(1);
      end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator
module tb_voice_allocator;
  logic CLK = 0, RST_N = 0, MIDI_MSG_RDY = 0;
  logic [23:0] MIDI_MSG = '0, VOICE_MSG;
  logic [3:0] voice_active = '0, VOICE_MSG_RDY;
  logic STEAL;
  logic [7:0] OVF_CNT;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [23:0] msg; logic [3:0] mask; logic steal; int cyc;} exp_t;
  exp_t sb[$];

  voice_allocator #(.NUM_VOICES(4), .IDX_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .MIDI_MSG(MIDI_MSG), .MIDI_MSG_RDY(MIDI_MSG_RDY),
    .VOICE_ACTIVE(voice_active), .VOICE_MSG(VOICE_MSG), .VOICE_MSG_RDY(VOICE_MSG_RDY),
    .STEAL(STEAL), .OVF_CNT(OVF_CNT));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && (VOICE_MSG_RDY !== 4'b0 || STEAL !== 1'b0)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe rdy=%b steal=%b msg=%h", VOICE_MSG_RDY, STEAL, VOICE_MSG);
        end else begin
          e = sb.pop_front();
          if ({VOICE_MSG_RDY, VOICE_MSG, STEAL} !== {e.mask, e.msg, e.steal}) begin
            errors++;
            $display("FAIL dispatch got rdy=%b msg=%h steal=%b want rdy=%b msg=%h steal=%b",
                     VOICE_MSG_RDY, VOICE_MSG, STEAL, e.mask, e.msg, e.steal);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cyc !== e.cyc) begin
              errors++;
              $display("FAIL latency got cycle %0d want %0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [23:0] m, input logic [3:0] mk, input logic st, input bit lat);
    exp_t e;
    MIDI_MSG = m;
    MIDI_MSG_RDY = 1;
    if (mk != 0) begin
      e.msg = m; e.mask = mk; e.steal = st; e.cyc = lat ? cyc + 2 : -1;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    MIDI_MSG_RDY = 0;
  endtask

  task automatic apply_reset();
    RST_N = 0;
    MIDI_MSG_RDY = 0;
    sb.delete();
    idle(2);
    RST_N = 1;
    idle(1);
  endtask

  task automatic drain(input string name);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got %0d outstanding want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({VOICE_MSG_RDY, STEAL, OVF_CNT, VOICE_MSG} !== 37'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b steal=%b ovf=%0d msg=%h want zeros",
               VOICE_MSG_RDY, STEAL, OVF_CNT, VOICE_MSG);
    end
  endtask

  task automatic test_on_off();
    voice_active = 4'b0000;
    send(24'h903C64, 4'b0001, 0, 1); idle(3);
    send(24'h803C00, 4'b0001, 0, 1); idle(3);
    send(24'h903D40, 4'b0001, 0, 1); idle(3);
    drain("on_off");
  endtask

  task automatic test_steal();
    apply_reset();
    voice_active = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send({8'h90, 8'h40 + 8'(i), 8'h50}, 4'b0001 << i, 0, 1);
      idle(3);
    end
    send(24'h904450, 4'b0001, 1, 1); idle(3);
    send(24'h904550, 4'b0010, 1, 1); idle(3);
    drain("steal");
  endtask

  task automatic test_priority();
    apply_reset();
    voice_active = 4'b0000;
    send(24'h903040, 4'b0001, 0, 0); idle(3);
    send(24'h903140, 4'b0010, 0, 0); idle(3);
    send(24'h903240, 4'b0100, 0, 0); idle(3);
    send(24'h803200, 4'b0100, 0, 0); idle(3);
    voice_active = 4'b0100;
    send(24'h903340, 4'b1000, 0, 0); idle(3);
    voice_active = 4'b1100;
    send(24'h903440, 4'b0100, 0, 0); idle(3);
    drain("priority");
  endtask

  task automatic test_off_ano();
    apply_reset();
    voice_active = 4'b0000;
    send(24'h903C40, 4'b0001, 0, 0); idle(3);
    send(24'h904040, 4'b0010, 0, 0); idle(3);
    send(24'h903C40, 4'b0100, 0, 0); idle(3);
    send(24'h903C00, 4'b0101, 0, 0); idle(3);
    send(24'h803D00, 4'b0000, 0, 0); idle(3);
    send(24'hB07B00, 4'b1111, 0, 0); idle(3);
    send(24'h904140, 4'b0001, 0, 0); idle(3);
    drain("off_ano");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    voice_active = 4'b0000;
    send(24'h905040, 4'b0001, 0, 1);
    send(24'h805000, 4'b0001, 0, 0);
    send(24'h905140, 4'b0000, 0, 0);
    idle(6);
    checks++;
    if (OVF_CNT !== 8'd1) begin
      errors++;
      $display("FAIL ovf_cnt got %0d want 1", OVF_CNT);
    end
    send(24'h805100, 4'b0000, 0, 0); idle(3);
    send(24'h913C40, 4'b0000, 0, 0); idle(3);
    send(24'hE00040, 4'b0000, 0, 0); idle(3);
    drain("back_to_back");
    checks++;
    if (OVF_CNT !== 8'd1) begin
      errors++;
      $display("FAIL ovf_after_discard got %0d want 1", OVF_CNT);
    end
  endtask

  task automatic test_reset_midflight();
    voice_active = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send({8'h90, 8'h60 + 8'(i), 8'h50}, 4'b0001 << i, 0, 0);
      idle(3);
    end
    send(24'h906450, 4'b0001, 1, 0); idle(3);
    send(24'h906550, 4'b0000, 0, 0);
    idle(1);
    checks++;
    if ({VOICE_MSG_RDY, STEAL} !== 5'b00101) begin
      errors++;
      $display("FAIL pre_reset_dispatch got rdy=%b steal=%b want rdy=0010 steal=1", VOICE_MSG_RDY, STEAL);
    end
    RST_N = 0;
    #1;
    checks++;
    if ({VOICE_MSG_RDY, STEAL, VOICE_MSG} !== 29'b0) begin
      errors++;
      $display("FAIL reset_kill got rdy=%b steal=%b msg=%h want zeros", VOICE_MSG_RDY, STEAL, VOICE_MSG);
    end
    idle(2);
    RST_N = 1;
    sb.delete();
    idle(1);
    checks++;
    if (OVF_CNT !== 8'd0) begin
      errors++;
      $display("FAIL ovf_after_reset got %0d want 0", OVF_CNT);
    end
    for (int i = 0; i < 4; i++) begin
      send({8'h90, 8'h70 + 8'(i), 8'h50}, 4'b0001 << i, 0, 1);
      idle(3);
    end
    send(24'h907450, 4'b0001, 1, 1); idle(3);
    drain("reset_midflight");
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_on_off();
    test_steal();
    test_priority();
    test_off_ano();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
